// File: rtl/bitcoin_hash_multi_if.sv
// Host-side bundle for the multi-core nonce sweeper: job request, result flags
// and the single-port memory bus.
interface bitcoin_hash_multi_if #(parameter int ADDR_W = 16);
  logic              start;
  logic [ADDR_W-1:0] message_addr;
  logic [ADDR_W-1:0] output_addr;
  logic [31:0]       nonce_base;
  logic [31:0]       target_h0;
  logic              done;
  logic              found;
  logic [31:0]       found_nonce;
  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport master (
    output start, message_addr, output_addr, nonce_base, target_h0, mem_read_data,
    input  done, found, found_nonce, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    input  start, message_addr, output_addr, nonce_base, target_h0, mem_read_data,
    output done, found, found_nonce, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/bitcoin_hash_multi.sv
// Nonce-sweep miner: one midstate pass, then NUM_CORES parallel double-SHA-256
// lanes per batch, writing each final H0 and tracking the first winner.
module sha256_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] block [16],
  input  logic [31:0] iv [8],
  output logic        done,
  output logic [31:0] digest [8]
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [31:0] w [16];
  logic [31:0] s [8];
  logic [31:0] base [8];
  logic [6:0]  rnd;
  logic        busy;
  logic [31:0] t1, t2, w_next;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always_comb begin
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25)) +
         ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[rnd[5:0]] + w[0];
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22)) +
         ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9] +
             (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  // One round per cycle over a sliding 16-word schedule window; a 65th cycle adds the IV back.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      rnd  <= 7'd0;
    end else begin
      done <= 1'b0;
      if (!busy && start) begin
        busy <= 1'b1;
        rnd  <= 7'd0;
        s    <= iv;
        base <= iv;
        w    <= block;
      end else if (busy && rnd != 7'd64) begin
        s[7] <= s[6];
        s[6] <= s[5];
        s[5] <= s[4];
        s[4] <= s[3] + t1;
        s[3] <= s[2];
        s[2] <= s[1];
        s[1] <= s[0];
        s[0] <= t1 + t2;
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_next;
        rnd   <= rnd + 7'd1;
      end else if (busy) begin
        for (int i = 0; i < 8; i++) digest[i] <= s[i] + base[i];
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

module bitcoin_hash_multi #(
  parameter int NUM_NONCES = 16,
  parameter int NUM_CORES  = 4,
  parameter int ADDR_W     = 16
) (
  input logic clk,
  input logic reset,
  bitcoin_hash_multi_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, MID, BATCH2, BATCH3, WRITE, DONE} state_t;

  localparam logic [31:0] STD_IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  state_t               state;
  logic [ADDR_W-1:0]    msg_addr_q, out_addr_q;
  logic [31:0]          nonce_base_q, target_q;
  logic [31:0]          header [20];
  logic [31:0]          midstate [8];
  logic [4:0]           read_cnt;
  logic [8:0]           batch_base;
  logic [3:0]           slot;
  logic                 launched;
  logic [NUM_CORES-1:0] core_start, core_done, done_seen, active;
  logic [31:0]          core_block [NUM_CORES][16];
  logic [31:0]          core_iv [NUM_CORES][8];
  logic [31:0]          core_digest [NUM_CORES][8];
  logic [8:0]           write_idx;
  logic [31:0]          write_h0;

  assign bus.mem_clk = clk;

  // Per-lane block/IV selection; BATCH3 rehashes the lane's own first-pass digest.
  always_comb begin
    write_idx = batch_base + 9'(slot);
    write_h0  = 32'h0;
    for (int c = 0; c < NUM_CORES; c++) begin
      active[c] = (int'(batch_base) + c) < NUM_NONCES;
      if (int'(slot) == c) write_h0 = core_digest[c][0];
      core_iv[c] = STD_IV;
      for (int k = 0; k < 16; k++) core_block[c][k] = 32'h0;
      if (state == MID) begin
        for (int k = 0; k < 16; k++) core_block[c][k] = header[k];
      end else if (state == BATCH2) begin
        core_iv[c]        = midstate;
        core_block[c][0]  = header[16];
        core_block[c][1]  = header[17];
        core_block[c][2]  = header[18];
        core_block[c][3]  = nonce_base_q + 32'(int'(batch_base) + c);
        core_block[c][4]  = 32'h80000000;
        core_block[c][15] = 32'd640;
      end else begin
        for (int k = 0; k < 8; k++) core_block[c][k] = core_digest[c][k];
        core_block[c][8]  = 32'h80000000;
        core_block[c][15] = 32'd256;
      end
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    sha256_core u_core (
      .clk    (clk),
      .reset  (reset),
      .start  (core_start[c]),
      .block  (core_block[c]),
      .iv     (core_iv[c]),
      .done   (core_done[c]),
      .digest (core_digest[c])
    );
  end

  // Lane done pulses are OR-accumulated so a batch only advances once every active lane reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      bus.done           <= 1'b0;
      bus.found          <= 1'b0;
      bus.found_nonce    <= 32'h0;
      bus.mem_we         <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= 32'h0;
      core_start         <= '0;
      done_seen          <= '0;
      launched           <= 1'b0;
      read_cnt           <= 5'd0;
      batch_base         <= 9'd0;
      slot               <= 4'd0;
    end else begin
      bus.done   <= 1'b0;
      bus.mem_we <= 1'b0;
      core_start <= '0;
      case (state)
        IDLE: if (bus.start) begin
          msg_addr_q      <= bus.message_addr;
          out_addr_q      <= bus.output_addr;
          nonce_base_q    <= bus.nonce_base;
          target_q        <= bus.target_h0;
          bus.found       <= 1'b0;
          bus.found_nonce <= 32'h0;
          bus.mem_addr    <= bus.message_addr;
          read_cnt        <= 5'd0;
          batch_base      <= 9'd0;
          launched        <= 1'b0;
          state           <= READ;
        end
        READ: begin
          if (read_cnt != 5'd0) header[read_cnt - 5'd1] <= bus.mem_read_data;
          if (read_cnt < 5'd19) bus.mem_addr <= msg_addr_q + ADDR_W'(read_cnt + 5'd1);
          if (read_cnt == 5'd20) state <= MID;
          else read_cnt <= read_cnt + 5'd1;
        end
        MID: if (!launched) begin
          core_start[0] <= 1'b1;
          launched      <= 1'b1;
        end else if (core_done[0]) begin
          midstate <= core_digest[0];
          launched <= 1'b0;
          state    <= BATCH2;
        end
        BATCH2, BATCH3: if (!launched) begin
          core_start <= active;
          done_seen  <= '0;
          launched   <= 1'b1;
        end else if (((done_seen | core_done) & active) == active) begin
          launched <= 1'b0;
          slot     <= 4'd0;
          state    <= (state == BATCH2) ? BATCH3 : WRITE;
        end else begin
          done_seen <= done_seen | core_done;
        end
        WRITE: begin
          bus.mem_we         <= 1'b1;
          bus.mem_addr       <= out_addr_q + ADDR_W'(write_idx);
          bus.mem_write_data <= write_h0;
          if (write_h0 < target_q && !bus.found) begin
            bus.found       <= 1'b1;
            bus.found_nonce <= nonce_base_q + 32'(write_idx);
          end
          if (int'(write_idx) == NUM_NONCES - 1) begin
            state <= DONE;
          end else if (int'(slot) == NUM_CORES - 1) begin
            batch_base <= batch_base + 9'(NUM_CORES);
            state      <= BATCH2;
          end else begin
            slot <= slot + 4'd1;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitcoin_hash_multi.sv
// Bench for bitcoin_hash_multi: a 16-nonce and a 10-nonce instance share one memory,
// results are compared against a behavioural double-SHA-256 model.
module tb_bitcoin_hash_multi;
  localparam int ADDR_W = 16;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] STD_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] HEADER [20] = '{
    32'h02000000, 32'h17975b97, 32'hc18ed1f7, 32'he255adf2, 32'h97599b55, 32'h330edab8, 32'h7803c817, 32'h01000000,
    32'h00000000, 32'h8a97295a, 32'h2747b4f1, 32'ha0b3948d, 32'hf3990344, 32'hc0e19fa6, 32'hb2b92b3a, 32'h19c8e6ba,
    32'hdc141787, 32'h358b0553, 32'h535f0119, 32'h48750833};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        start_req = 1'b0;
  logic [15:0] message_addr = 16'h0, output_addr = 16'h0;
  logic [31:0] nonce_base = 32'h0, target_h0 = 32'h0;
  logic [31:0] rd_data;
  bit   [31:0] mem [65536];
  int          cycle = 0, start_cycle = 0, done_cycle = 0;
  int          write_count = 0, done_count = 0, stray_count = 0;
  int          checks = 0, passes = 0;
  logic [31:0] exp_h0 [16];
  logic        exp_found;
  logic [31:0] exp_nonce;

  always #5 clk = ~clk;

  bitcoin_hash_multi_if #(.ADDR_W(ADDR_W)) bus16 ();
  bitcoin_hash_multi_if #(.ADDR_W(ADDR_W)) bus10 ();

  assign bus16.start         = start_req && !sel;
  assign bus16.message_addr  = message_addr;
  assign bus16.output_addr   = output_addr;
  assign bus16.nonce_base    = nonce_base;
  assign bus16.target_h0     = target_h0;
  assign bus16.mem_read_data = rd_data;
  assign bus10.start         = start_req && sel;
  assign bus10.message_addr  = message_addr;
  assign bus10.output_addr   = output_addr;
  assign bus10.nonce_base    = nonce_base;
  assign bus10.target_h0     = target_h0;
  assign bus10.mem_read_data = rd_data;

  bitcoin_hash_multi #(.NUM_NONCES(16), .NUM_CORES(4), .ADDR_W(ADDR_W)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16));
  bitcoin_hash_multi #(.NUM_NONCES(10), .NUM_CORES(4), .ADDR_W(ADDR_W)) dut10 (
    .clk(clk), .reset(reset), .bus(bus10));

  // Registered read port: data for an address appears the following cycle.
  always @(posedge clk) begin
    cycle   <= cycle + 1;
    rd_data <= mem[sel ? bus10.mem_addr : bus16.mem_addr];
  end

  // Writes, done pulses and any activity from the deselected instance are observed mid-cycle.
  always @(negedge clk) begin
    if (sel ? bus10.mem_we : bus16.mem_we) begin
      mem[sel ? bus10.mem_addr : bus16.mem_addr] = sel ? bus10.mem_write_data : bus16.mem_write_data;
      write_count++;
    end
    if (sel ? bus10.done : bus16.done) begin
      done_count++;
      done_cycle = cycle;
    end
    if ((sel ? bus16.mem_we : bus10.mem_we) === 1'b1 || (sel ? bus16.done : bus10.done) === 1'b1)
      stray_count++;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = st[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i] + st[255-32*i -: 32];
    return r;
  endfunction

  function automatic logic [31:0] model_h0(input logic [31:0] nonce);
    logic [511:0] b;
    logic [255:0] mid, h1, h2;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = HEADER[i];
    mid = compress(STD_IV, b);
    h1  = compress(mid, {HEADER[16], HEADER[17], HEADER[18], nonce, 32'h80000000, 320'd0, 32'd640});
    h2  = compress(STD_IV, {h1, 32'h80000000, 192'd0, 32'd256});
    return h2[255:224];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic build_expected(input logic [31:0] base, input int n, input logic [31:0] tgt);
    exp_found = 1'b0;
    exp_nonce = 32'h0;
    for (int i = 0; i < n; i++) begin
      exp_h0[i] = model_h0(base + 32'(i));
      if (!exp_found && exp_h0[i] < tgt) begin
        exp_found = 1'b1;
        exp_nonce = base + 32'(i);
      end
    end
  endtask

  task automatic prepare_output(input logic [15:0] out, input int n);
    for (int i = 0; i < n; i++) mem[16'(out + 16'(i))] = 32'h0;
    mem[16'(out + 16'(n))]     = 32'hDEADBEEF;
    mem[16'(out + 16'(n + 1))] = 32'hDEADBEEF;
  endtask

  task automatic apply_stimulus(input logic [15:0] msg, input logic [15:0] out,
                                input logic [31:0] base, input logic [31:0] tgt);
    @(negedge clk);
    message_addr = msg;
    output_addr  = out;
    nonce_base   = base;
    target_h0    = tgt;
    start_req    = 1'b1;
    start_cycle  = cycle;
    @(negedge clk);
    start_req = 1'b0;
  endtask

  task automatic wait_done(input int d0, output int latency);
    int n = 0;
    while (done_count == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    latency = done_cycle - start_cycle;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_words(input string tag, input logic [15:0] out, input int n);
    for (int i = 0; i < n; i++)
      check_output($sformatf("%s_word%0d", tag, i), mem[16'(out + 16'(i))], exp_h0[i]);
    check_output({tag, "_guard0"}, mem[16'(out + 16'(n))], 32'hDEADBEEF);
    check_output({tag, "_guard1"}, mem[16'(out + 16'(n + 1))], 32'hDEADBEEF);
  endtask

  initial begin
    int w0, d0, lat1, lat2;
    for (int i = 0; i < 20; i++) begin
      mem[16'h0100 + 16'(i)]    = HEADER[i];
      mem[16'(16'hFFF8 + 16'(i))] = HEADER[i];
    end

    repeat (3) @(negedge clk);
    check_output("rst_done",     bus16.done, 32'h0);
    check_output("rst_found",    bus16.found, 32'h0);
    check_output("rst_nonce",    bus16.found_nonce, 32'h0);
    check_output("rst_we",       bus16.mem_we, 32'h0);
    check_output("rst_addr",     bus16.mem_addr, 32'h0);
    check_output("rst_wdata",    bus16.mem_write_data, 32'h0);
    check_output("rst_done10",   bus10.done, 32'h0);
    check_output("rst_we10",     bus10.mem_we, 32'h0);
    reset = 1'b0;

    // Full 16-nonce sweep, every nonce wins so the first index is reported.
    build_expected(32'h0, 16, 32'hFFFFFFFF);
    prepare_output(16'h0200, 16);
    w0 = write_count; d0 = done_count;
    apply_stimulus(16'h0100, 16'h0200, 32'h0, 32'hFFFFFFFF);
    wait_done(d0, lat1);
    check_words("run16", 16'h0200, 16);
    check_output("run16_writes", write_count - w0, 16);
    check_output("run16_dones",  done_count - d0, 1);
    check_output("run16_found",  bus16.found, 32'h1);
    check_output("run16_nonce",  bus16.found_nonce, 32'h0);

    // Mid-range target plus an ignored second start with different parameters.
    build_expected(32'h0, 16, exp_h0[5]);
    prepare_output(16'h0200, 16);
    w0 = write_count; d0 = done_count;
    apply_stimulus(16'h0100, 16'h0200, 32'h0, exp_h0[5]);
    check_output("rerun_found_clr", bus16.found, 32'h0);
    repeat (50) @(negedge clk);
    output_addr = 16'h0500; nonce_base = 32'h55555555; target_h0 = 32'h0;
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    wait_done(d0, lat2);
    check_words("rerun", 16'h0200, 16);
    check_output("rerun_writes",  write_count - w0, 16);
    check_output("rerun_dones",   done_count - d0, 1);
    check_output("rerun_latency", lat2, lat1);
    check_output("rerun_found",   bus16.found, exp_found);
    check_output("rerun_nonce",   bus16.found_nonce, exp_nonce);

    // Partial final batch, nonce wrap, header read wrapping past 0xFFFF, unreachable target.
    sel = 1'b1;
    build_expected(32'hFFFFFFFE, 10, 32'h0);
    prepare_output(16'h0300, 10);
    w0 = write_count; d0 = done_count;
    apply_stimulus(16'hFFF8, 16'h0300, 32'hFFFFFFFE, 32'h0);
    wait_done(d0, lat1);
    check_words("wrap10", 16'h0300, 10);
    check_output("wrap10_writes", write_count - w0, 10);
    check_output("wrap10_dones",  done_count - d0, 1);
    check_output("wrap10_found",  bus10.found, 32'h0);

    // Reset while the first batch is hashing: no writes and no done afterwards.
    w0 = write_count; d0 = done_count;
    apply_stimulus(16'h0100, 16'h0400, 32'h12345678, 32'hFFFFFFFF);
    repeat (118) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("abort_we",   bus10.mem_we, 32'h0);
    check_output("abort_done", bus10.done, 32'h0);
    repeat (300) @(negedge clk);
    check_output("abort_writes", write_count - w0, 0);
    check_output("abort_dones",  done_count - d0, 0);

    // Clean restart after the abort, output region wrapping past 0xFFFF.
    build_expected(32'h12345678, 10, 32'hFFFFFFFF);
    prepare_output(16'hFFFC, 10);
    w0 = write_count; d0 = done_count;
    apply_stimulus(16'h0100, 16'hFFFC, 32'h12345678, 32'hFFFFFFFF);
    wait_done(d0, lat1);
    check_words("restart", 16'hFFFC, 10);
    check_output("restart_writes", write_count - w0, 10);
    check_output("restart_dones",  done_count - d0, 1);
    check_output("restart_found",  bus10.found, 32'h1);
    check_output("restart_nonce",  bus10.found_nonce, 32'h12345678);

    check_output("idle_instance_quiet", stray_count, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bitcoin_hash_multi.md
Name: bitcoin_hash_multi

Overview:
Parametrised successor of the nonce-sweep miner. It reads a 20-word block header from memory and computes the first-block SHA-256 midstate once. It then double-hashes NUM_NONCES consecutive nonces on NUM_CORES parallel compression cores and writes the H0 word of each final digest to memory. It also compares every final H0 against a programmable target and reports the first winning nonce. It sits between the testbench memory and the existing sha256_core compression engine (ports: start, block[16], iv[8], done, digest[8]; fixed 64+ cycle latency, done is a 1-cycle pulse).

Parameters:
NUM_NONCES, 16, nonces swept per start (1..256)
NUM_CORES, 4, parallel sha256_core instances (1..16); need not divide NUM_NONCES
ADDR_W, 16, memory address width

Ports:
clk  in  1  single clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  1-cycle request; sampled only in IDLE
message_addr  in  ADDR_W  base address of the 20 header words
output_addr  in  ADDR_W  base address of the NUM_NONCES output words
nonce_base  in  32  first nonce value
target_h0  in  32  success threshold on final H0 (unsigned)
done  out  1  1-cycle pulse at end of run
found  out  1  a nonce met the target; held until next accepted start
found_nonce  out  32  nonce value of the lowest-index winner; held with found
mem_clk  out  1  equals clk
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory address
mem_write_data  out  32  write data
mem_read_data  in  32  read data, valid the cycle after mem_addr is presented

Behaviour:
- Reset values: done=0, found=0, found_nonce=0, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE. All core starts are deasserted.
- Reset mid-run: abandon the run and return to IDLE next cycle. No further writes; done is not pulsed. Core outputs after reset are ignored until a new start.
- On accepted start, latch message_addr, output_addr, nonce_base and target_h0. Clear found and found_nonce.
- States: IDLE -> READ -> MID -> BATCH2 -> BATCH3 -> WRITE -> (BATCH2 | DONE) -> IDLE.
- READ: issue addresses message_addr+0..19 on 20 consecutive cycles and capture word k one cycle later. Exit after the 20th word is captured (21 cycles).
- MID: core 0 hashes words 0..15 with the standard IV and the result is stored as the midstate. The other cores are idle.
- BATCH2, batch b: core c is active if idx = b*NUM_CORES+c < NUM_NONCES. Its block is words 16..18, then nonce_base+idx (32-bit wrap), then 0x80000000, then ten zeros, then 640. Its IV is the midstate. Start all active cores in the same cycle and wait for every active done.
- BATCH3: each active core hashes its digest words 0..7, then 0x80000000, then six zeros, then 256, with the standard IV.
- WRITE: one word per cycle, in ascending idx. Set mem_we=1, mem_addr=output_addr+idx, mem_write_data=final H0.
  - Compare in the same cycle: if H0 < target_h0 (unsigned) and found=0, set found=1 and found_nonce=nonce_base+idx.
  - After the last active core, go to the next batch, or to DONE if idx reaches NUM_NONCES-1.
- DONE: pulse done for 1 cycle with mem_we=0, then return to IDLE.
- Inactive cores in a partial final batch are not started and produce no write.
- Address arithmetic wraps modulo 2^ADDR_W.
- start asserted outside IDLE is ignored.
- target_h0=0 can never be met; found stays 0.

Test Plan:
- NUM_NONCES=16, NUM_CORES=4, nonce_base=0, header from the class vector -> 16 writes at output_addr..+15 matching the software double-SHA H0 per nonce; exactly 4 BATCH2/BATCH3 rounds; done pulses once.
- NUM_NONCES=10, NUM_CORES=4 -> 10 writes only; third batch has 2 active cores; no write to output_addr+10 or +11.
- target_h0=0xFFFFFFFF -> found=1, found_nonce=nonce_base. target_h0=0 -> found=0 after done.
- nonce_base=0xFFFFFFFE, NUM_NONCES=4 -> hashed nonces are 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, each matching the model.
- reset asserted 1 cycle during BATCH2 -> next cycle IDLE, mem_we=0, no done; a new start then completes with correct results.
- start re-asserted mid-run -> ignored; write count and done timing are unchanged.
